// File: rtl/pixel_axi_write_scheduler.sv
// pixel_axi_write_scheduler: queues pixel write-back burst descriptors
// and frames them onto a single AXI4 write master port.
module pixel_axi_write_scheduler #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        desc_valid_i,
  input  logic [2:0]  desc_len_i,
  input  logic [31:0] desc_addr_i,
  output logic        desc_ready_2_o,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [31:0] pix_data_i,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic [7:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  input  logic        err_clr_i,
  output logic        idle_o,
  output logic [1:0]  err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0] MAX_O = 8'(MAX_OUTSTANDING);

  typedef enum logic {AW_IDLE, AW_REQ} aw_state_t;
  typedef enum logic {W_IDLE, W_BURST} w_state_t;

  aw_state_t aw_state, aw_next;
  w_state_t  w_state, w_next;

  logic [34:0]   aq_mem [DEPTH];
  logic [2:0]    wq_mem [DEPTH];
  logic [PW-1:0] aq_wp, aq_rp, wq_wp, wq_rp;
  logic [CW-1:0] aq_cnt, wq_cnt;
  logic [CW-1:0] aq_cnt_n, wq_cnt_n, max_n;
  logic [7:0]    outst;
  logic [2:0]    beat_len, beat_cnt;
  logic [31:0]   aw_addr_q;
  logic [2:0]    aw_len_q;
  logic          push, ovf, aq_pop, wq_pop;
  logic          aw_hs, w_hs, b_hs, b_err, b_dec;

  assign push   = desc_valid_i && aq_cnt != DEPTH_C
               && wq_cnt != DEPTH_C;
  assign ovf    = desc_valid_i && !push;
  assign aq_pop = aw_state == AW_IDLE && aq_cnt != '0
               && outst < MAX_O;
  assign wq_pop = w_state == W_IDLE && wq_cnt != '0;
  assign aw_hs  = awvalid_o && awready_i;
  assign w_hs   = wvalid_o && wready_i;
  assign b_hs   = bvalid_i && bready_o;
  assign b_err  = b_hs && bresp_i != 2'b00;
  // a B with nothing outstanding is a stray and must not underflow
  assign b_dec  = b_hs && outst != '0;

  assign aq_cnt_n = aq_cnt + CW'(push) - CW'(aq_pop);
  assign wq_cnt_n = wq_cnt + CW'(push) - CW'(wq_pop);
  assign max_n    = (aq_cnt_n > wq_cnt_n) ? aq_cnt_n : wq_cnt_n;

  always_ff @(posedge clk) begin
    if (push) begin
      aq_mem[aq_wp] <= {desc_addr_i, desc_len_i};
      wq_mem[wq_wp] <= desc_len_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq_wp          <= '0;
      aq_rp          <= '0;
      wq_wp          <= '0;
      wq_rp          <= '0;
      aq_cnt         <= '0;
      wq_cnt         <= '0;
      desc_ready_2_o <= 1'b1;
    end else begin
      if (push) begin
        aq_wp <= aq_wp + PW'(1);
        wq_wp <= wq_wp + PW'(1);
      end
      if (aq_pop) aq_rp <= aq_rp + PW'(1);
      if (wq_pop) wq_rp <= wq_rp + PW'(1);
      aq_cnt         <= aq_cnt_n;
      wq_cnt         <= wq_cnt_n;
      desc_ready_2_o <= (DEPTH_C - max_n) >= CW'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_state  <= AW_IDLE;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
    end else begin
      aw_state <= aw_next;
      if (aq_pop) {aw_addr_q, aw_len_q} <= aq_mem[aq_rp];
    end
  end

  always_comb begin
    aw_next = aw_state;
    unique case (aw_state)
      AW_IDLE: if (aq_pop) aw_next = AW_REQ;
      AW_REQ:  if (awready_i) aw_next = AW_IDLE;
    endcase
  end

  always_comb begin
    awvalid_o = aw_state == AW_REQ;
    awaddr_o  = aw_addr_q;
    awlen_o   = {5'b0, aw_len_q};
    awsize_o  = 3'b010;
    awburst_o = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      beat_len <= '0;
      beat_cnt <= '0;
    end else begin
      w_state <= w_next;
      if (wq_pop) begin
        beat_len <= wq_mem[wq_rp];
        beat_cnt <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (wq_pop) w_next = W_BURST;
      W_BURST: if (w_hs && wlast_o) w_next = W_IDLE;
    endcase
  end

  // data path is a pure pass-through while a burst is open
  always_comb begin
    wvalid_o    = 1'b0;
    pix_ready_o = 1'b0;
    wdata_o     = '0;
    wlast_o     = 1'b0;
    wstrb_o     = 4'hF;
    if (w_state == W_BURST) begin
      wvalid_o    = pix_valid_i;
      pix_ready_o = wready_i;
      wdata_o     = pix_data_i;
      wlast_o     = beat_cnt == beat_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst    <= '0;
      bready_o <= 1'b0;
      err_o    <= '0;
      idle_o   <= 1'b1;
    end else begin
      if (aw_hs && !b_dec) outst <= outst + 8'd1;
      else if (!aw_hs && b_dec) outst <= outst - 8'd1;
      bready_o <= 1'b1;
      err_o    <= (err_o & ~{2{err_clr_i}}) | {ovf, b_err};
      idle_o   <= aq_cnt == '0 && wq_cnt == '0
               && aw_state == AW_IDLE && w_state == W_IDLE
               && outst == '0;
    end
  end

endmodule
